inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter INST_W, default 16, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, instruction address width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 10, number of valid instruction words; legal addresses are 0..MEM_DEPTH-1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port readaddr  output  ADDR_W  address presented to the instruction memory.
REQ-007 SHALL have port inst  input  INST_W  instruction returned combinationally for readaddr in the same cycle.
REQ-008 SHALL have port branch_en  input  1  redirect request, sampled each edge.
REQ-009 SHALL have port branch_target  input  ADDR_W  redirect address.
REQ-010 SHALL have port id_ready  input  1  downstream decode can accept an instruction.
REQ-011 SHALL have port if_valid  output  1  if_inst and if_pc are valid.
REQ-012 SHALL have port if_inst  output  INST_W  head-of-queue instruction.
REQ-013 SHALL have port if_pc  output  ADDR_W  address of if_inst.
REQ-014 SHALL have port halted  output  1  fetch stopped on a halt word.

Function
REQ-015 SHALL hold a program counter pc, driven directly onto readaddr.
REQ-016 SHALL buffer fetched {pc, inst} pairs in a 2-entry FIFO; if_valid = (count != 0), and if_inst/if_pc = head entry, registered.
REQ-017 SHALL pop the head on any edge where if_valid && id_ready.
REQ-018 SHALL push {pc, inst} and advance pc on an edge when not halted, branch_en low, and (count < 2 or a pop occurs on the same edge).
REQ-019 SHALL advance pc as pc+1, wrapping from MEM_DEPTH-1 to 0.
REQ-020 SHALL, on simultaneous push and pop with count 2, keep count 2 with FIFO order preserved.
REQ-021 SHALL, on an edge with branch_en high, flush the FIFO (count 0), perform no push, and load pc with branch_target; a pop on that edge is still treated as a completed handshake.
REQ-022 SHALL load pc with 0 when branch_target >= MEM_DEPTH.
REQ-023 SHALL give a latency of one edge from pc update to the corresponding entry appearing on if_valid when the FIFO is empty.
REQ-024 SHALL hold if_inst/if_pc stable while if_valid && !id_ready.
REQ-025 SHALL deliver instructions in strict fetch order with none dropped or duplicated, except entries flushed by branch_en.

Reset
REQ-026 SHALL, on any edge with reset high, set pc=0, readaddr=0, count=0, if_valid=0, if_inst=0, if_pc=0, halted=0; reset overrides branch_en and all handshakes.
REQ-027 SHALL, on reset asserted mid-operation, discard all buffered entries; the first entry after release is address 0.

Configuration
REQ-028 SHALL, with FETCH_HALT_EN defined, treat a pushed inst equal to all ones as a halt word: it is enqueued, halted is set on that edge, and no further pushes occur until reset or branch_en clears halted.
REQ-029 SHALL, without FETCH_HALT_EN defined, tie halted to 0 and treat an all-ones word as an ordinary instruction.

Verification
REQ-030 SHALL cover: reset, id_ready=1, memory words 0..9 -> if_pc 0,1,2,... one per cycle starting one edge after release, wrapping 9 -> 0.
REQ-031 SHALL cover: id_ready=0 for 5 cycles from reset release -> count reaches 2, pc stops at 2, if_pc holds 0; on id_ready=1, if_pc 0,1,2 back-to-back.
REQ-032 SHALL cover: branch_en with branch_target=7 while count=2 -> if_valid low next cycle, then if_pc 7,8,9,0.
REQ-033 SHALL cover: branch_target=12 -> fetch resumes at if_pc 0.
REQ-034 SHALL cover: FETCH_HALT_EN, word 3 = 16'hFFFF -> if_pc 0..3 delivered, halted=1, no further pushes; branch_en target 0 clears halted.
REQ-035 SHALL cover: reset asserted while count=2 -> all outputs zero next edge, first if_pc after release is 0.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: PC-driven instruction fetch into a 2-entry FIFO with branch redirect; halt-word stop is enabled by defining FETCH_HALT_EN
module inst_fetch #(
  parameter int INST_W = 16,
  parameter int ADDR_W = 9,
  parameter int MEM_DEPTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] readaddr,
  input  logic [INST_W-1:0] inst,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);
  logic [ADDR_W-1:0] pc, pc_next, tgt, pc_b;
  logic [INST_W-1:0] inst_b;
  logic [1:0] count;
  logic pop, push, is_halt, halted_q;
  assign readaddr = pc;
  assign halted = halted_q;
  assign if_valid = count != 2'd0;
  assign pop = if_valid && id_ready;
  assign push = !halted_q && !branch_en && (count < 2'd2 || pop);
  assign pc_next = pc == ADDR_W'(MEM_DEPTH - 1) ? '0 : pc + ADDR_W'(1);
  assign tgt = 32'(branch_target) >= 32'(MEM_DEPTH) ? '0 : branch_target;
`ifdef FETCH_HALT_EN
  assign is_halt = &inst;
`else
  assign is_halt = 1'b0;
`endif
  // pc, FIFO (head drives if_inst/if_pc directly, second slot in pc_b/inst_b) and halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      count <= '0;
      if_inst <= '0;
      if_pc <= '0;
      pc_b <= '0;
      inst_b <= '0;
      halted_q <= 1'b0;
    end else if (branch_en) begin
      pc <= tgt;
      count <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        pc <= pc_next;
        halted_q <= is_halt;
      end
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        if_pc <= pc;
        if_inst <= inst;
      end else if (pop && count == 2'd2) begin
        if_pc <= pc_b;
        if_inst <= inst_b;
      end
      if (push && (count == 2'd2 || (count == 2'd1 && !pop))) begin
        pc_b <= pc;
        inst_b <= inst;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized scoreboard bench for inst_fetch against a queue-based fetch model
module tb_inst_fetch;
`ifdef FETCH_HALT_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif
  typedef struct packed {
    logic [8:0]  pc;
    logic [15:0] ins;
  } ent_t;
  logic clk = 1'b0, reset = 1'b1, branch_en = 1'b0, id_ready = 1'b0;
  logic [8:0] readaddr, branch_target = '0, if_pc;
  logic [15:0] inst, if_inst;
  logic if_valid, halted;
  logic [15:0] mem [10];
  ent_t exp_q [$];
  int mpc = 0, total = 0, bad = 0;
  bit mh = 1'b0;
  inst_fetch dut (
    .clk(clk), .reset(reset), .readaddr(readaddr), .inst(inst),
    .branch_en(branch_en), .branch_target(branch_target), .id_ready(id_ready),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .halted(halted)
  );
  always #5 clk = ~clk;
  assign inst = readaddr < 9'd10 ? mem[readaddr] : 16'h0000;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input bit r, input bit b, input int t, input bit y, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      reset = r;
      branch_en = b;
      branch_target = 9'(t);
      id_ready = y;
    end
  endtask
  task automatic chk_zero(input string n);
    @(negedge clk);
    chk({n, "_valid"}, 32'(if_valid), 32'd0);
    chk({n, "_inst"}, 32'(if_inst), 32'd0);
    chk({n, "_pc"}, 32'(if_pc), 32'd0);
    chk({n, "_addr"}, 32'(readaddr), 32'd0);
    chk({n, "_halted"}, 32'(halted), 32'd0);
  endtask
  // reference model: fetch order as a queue of {pc, word}, updated from pre-edge inputs
  always @(posedge clk) begin
    bit pop, push;
    if (reset) begin
      exp_q.delete();
      mpc = 0;
      mh = 1'b0;
    end else begin
      pop = exp_q.size() > 0 && id_ready;
      push = !mh && !branch_en && (exp_q.size() < 2 || pop);
      if (pop) void'(exp_q.pop_front());
      if (branch_en) begin
        exp_q.delete();
        mpc = int'(branch_target) >= 10 ? 0 : int'(branch_target);
        mh = 1'b0;
      end else if (push) begin
        exp_q.push_back({9'(mpc), mem[mpc]});
        if (HE && mem[mpc] == 16'hFFFF) mh = 1'b1;
        mpc = (mpc + 1) % 10;
      end
    end
  end
  // monitor: compare presented outputs against the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      chk("readaddr", 32'(readaddr), 32'(mpc));
      chk("halted", 32'(halted), 32'(mh));
      if (exp_q.size() != 0 && if_valid) begin
        chk("if_pc", 32'(if_pc), 32'(exp_q[0].pc));
        chk("if_inst", 32'(if_inst), 32'(exp_q[0].ins));
      end
    end
  end
  initial begin
    for (int i = 0; i < 10; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
    mem[3] = 16'hFFFF;
    drive(1, 0, 0, 1, 2);
    chk_zero("reset");
    drive(0, 0, 0, 1, 14);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 5);
    @(negedge clk);
    chk("stall_addr", 32'(readaddr), HE ? 32'd2 : 32'd2);
    chk("stall_pc", 32'(if_pc), 32'd0);
    drive(0, 0, 0, 1, 3);
    drive(0, 0, 0, 0, 3);
    drive(0, 1, 7, 0, 1);
    @(negedge clk);
    chk("flush_valid", 32'(if_valid), 32'd0);
    drive(0, 0, 0, 1, 6);
    drive(0, 1, 12, 1, 1);
    drive(0, 0, 0, 1, 4);
    drive(0, 1, 0, 1, 1);
    drive(0, 0, 0, 1, 10);
    @(negedge clk);
    chk("halt_state", 32'(halted), 32'(HE));
    drive(0, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 4);
    drive(1, 0, 0, 0, 1);
    chk_zero("midreset");
    drive(0, 0, 0, 1, 5);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, $urandom_range(0, 15), $urandom_range(0, 99) < 65, 1);
    drive(0, 0, 0, 1, 3);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
